tpu_cmd_sequencer: RTL and testbench
====================================

# tpu_cmd_sequencer

Sequencer between the CFU command/response handshake and the TPU datapath. It accepts one CFU instruction at a time and issues exactly one single-cycle TPU function strobe. For compute starts it waits on TPU completion; for readbacks it captures the TPU result. It holds the response until the CPU accepts it and keeps a cycle counter of the last compute run.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: WAIT_DONE cycle limit (only with TPU_SEQ_TIMEOUT_EN).
- CNT_W, 32: compute-cycle counter width (≤32, zero-extended on readout).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_payload_function_id  in  10  bits [2:0] = opcode; [9:3] ignored.
- cmd_payload_inputs_0 / cmd_payload_inputs_1  in  32 each  operands.
- rsp_valid  out  1  response valid, held until rsp_ready.
- rsp_ready  in  1  CPU accepts response.
- rsp_payload_outputs_0  out  32  response data, stable while rsp_valid.
- tpu_funct  out  3  TPU function strobe; nonzero for exactly one cycle per issue, else 0.
- tpu_input0 / tpu_input1  out  32 each  latched operands, valid while tpu_funct≠0.
- tpu_result  in  32  TPU read data, valid the cycle after tpu_funct=3 or 7.
- tpu_done  in  1  one-cycle TPU compute-complete pulse.
- tpu_abort  out  1  one-cycle abort pulse (timeout only).
- seq_busy  out  1  high in every state except IDLE.

## Operation
- Opcodes:
  - 0 = NOP: no issue; response 0.
  - 1, 2, 5 = config/load: issue; response 0.
  - 3 = read C, 7 = read index: issue; response is captured tpu_result.
  - 4 = start compute: issue, wait for tpu_done; response is the cycle count.
  - 6 = read last compute-cycle count: no issue.
- States and transitions:
  - IDLE: on cmd_valid && cmd_ready, latch opcode and operands. Opcode 0/6 → RESP; otherwise → ISSUE.
  - ISSUE: drive tpu_funct = opcode, tpu_input0/1 = latched operands. Next state: opcode 4 → WAIT_DONE; others → CAPTURE.
  - CAPTURE: out_reg ← tpu_result for 3/7, else 0 → RESP.
  - WAIT_DONE: cyc_cnt increments each cycle, starting at 1 in the first WAIT_DONE cycle. On tpu_done: last_cnt ← cyc_cnt, out_reg ← cyc_cnt → RESP.
  - RESP: rsp_valid=1; on rsp_ready → IDLE.
- cyc_cnt saturates at all-ones; it does not wrap.
- tpu_done outside WAIT_DONE is ignored. last_cnt is unchanged by all opcodes except 4.
- Asserting rst_n low in any state clears all state regardless of phase. After reset: IDLE; cmd_ready=1, rsp_valid=0, rsp_payload_outputs_0=0, tpu_funct=0, tpu_input0/1=0, tpu_abort=0, seq_busy=0, last_cnt=0, cyc_cnt=0. An interrupted TPU op is not retried.

## Timing
- Handshake at cycle T (state registered):
  - Opcodes 1/2/3/5/7: ISSUE at T+1, CAPTURE at T+2, rsp_valid at T+3.
  - Opcodes 0/6: rsp_valid at T+1.
  - Opcode 4: ISSUE at T+1, WAIT_DONE from T+2. tpu_done in cycle D gives rsp_valid at D+1.
- rsp_ready may be held high in advance; completion then takes one cycle in RESP.
- cmd_ready is low from T+1 until the cycle after the response handshake. No command overlap, no back-to-back acceptance.
- All outputs are registered except cmd_ready, seq_busy and rsp_valid, which decode the state register.

## Configuration
- TPU_SEQ_TIMEOUT_EN defined:
  - If WAIT_DONE reaches cyc_cnt == TIMEOUT_CYCLES without tpu_done, then tpu_abort pulses for one cycle, out_reg ← 32'hFFFF_FFFF, last_cnt is unchanged, and the state goes to RESP.
  - tpu_done arriving in the same cycle as the limit wins: normal completion, no abort.
- TPU_SEQ_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely; tpu_abort is tied to 0.

## Test plan
- Reset, then opcode 2 with in0=0x01020304, in1=0x05060708: tpu_funct=2 for exactly one cycle, with those operands at T+1; rsp_valid at T+3 with data 0.
- Opcode 7 with tpu_result=0x0000_0ABC at T+2: response 0x0000_0ABC. Hold rsp_ready low for 5 cycles: data stable, cmd_ready=0 throughout.
- Opcode 4 with tpu_done 10 cycles after ISSUE: response 10. Then opcode 6 returns 10. A tpu_done pulse while in IDLE is ignored.
- Assert rst_n low mid-WAIT_DONE: all outputs at reset values immediately (asynchronously); subsequent opcode 6 returns 0.
- With TPU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, opcode 4 with no tpu_done: tpu_abort pulses once, response 0xFFFFFFFF. Repeat with tpu_done on cycle 8: response 8, no abort.

Source files
------------

// File: rtl/tpu_cmd_sequencer.sv
// CFU command sequencer: one instruction at a time, one TPU strobe per issue, response held until accepted.
// Optional WAIT_DONE timeout/abort enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic [2:0]  tpu_funct,
    output logic [31:0] tpu_input0,
    output logic [31:0] tpu_input1,
    input  logic [31:0] tpu_result,
    input  logic        tpu_done,
    output logic        tpu_abort,
    output logic        seq_busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_WAIT, S_RESP} state_t;

    state_t           state, state_nx;
    logic [2:0]       op;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cyc_cnt, last_cnt;
    logic [31:0]      out_reg;
    logic             timeout_hit;

    assign cmd_op = cmd_payload_function_id[2:0];

`ifdef TPU_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    // a done pulse landing on the limit cycle takes priority over the abort
    assign timeout_hit = (cyc_cnt == TIMEOUT_LIM) && !tpu_done;
    logic unused_ok;
    assign unused_ok = &{1'b0, cmd_payload_function_id[9:3]};
`else
    assign timeout_hit = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, cmd_payload_function_id[9:3], (TIMEOUT_CYCLES != 0)};
`endif

    function automatic logic no_issue(input logic [2:0] o);
        return (o == 3'd0) || (o == 3'd6);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        seq_busy  = 1'b1;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                seq_busy  = 1'b0;
                if (cmd_valid) state_nx = no_issue(cmd_op) ? S_RESP : S_ISSUE;
            end
            S_ISSUE:   state_nx = (op == 3'd4) ? S_WAIT : S_CAPTURE;
            S_CAPTURE: state_nx = S_RESP;
            S_WAIT:    if (tpu_done || timeout_hit) state_nx = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= '0;
            tpu_funct  <= '0;
            tpu_input0 <= '0;
            tpu_input1 <= '0;
            tpu_abort  <= 1'b0;
            out_reg    <= '0;
            cyc_cnt    <= '0;
            last_cnt   <= '0;
        end else begin
            tpu_funct <= '0;
            tpu_abort <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op         <= cmd_op;
                    tpu_input0 <= cmd_payload_inputs_0;
                    tpu_input1 <= cmd_payload_inputs_1;
                    // strobe is registered so it lands exactly in the ISSUE cycle
                    if (!no_issue(cmd_op)) tpu_funct <= cmd_op;
                    out_reg <= (cmd_op == 3'd6) ? 32'(last_cnt) : '0;
                end
                S_ISSUE: if (op == 3'd4) cyc_cnt <= CNT_W'(1);
                S_CAPTURE: out_reg <= ((op == 3'd3) || (op == 3'd7)) ? tpu_result : '0;
                S_WAIT: begin
                    if (tpu_done) begin
                        last_cnt <= cyc_cnt;
                        out_reg  <= 32'(cyc_cnt);
                    end else if (timeout_hit) begin
                        tpu_abort <= 1'b1;
                        out_reg   <= '1;
                    end else if (cyc_cnt != '1) begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_payload_outputs_0 = out_reg;

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Directed bench for tpu_cmd_sequencer; timeout cases run when TPU_SEQ_TIMEOUT_EN is defined.
module tb_tpu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  function_id = '0;
    logic [31:0] in0 = '0, in1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [2:0]  tpu_funct;
    logic [31:0] tpu_input0, tpu_input1;
    logic [31:0] tpu_result = '0;
    logic        tpu_done = 1'b0;
    logic        tpu_abort;
    logic        seq_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tpu_cmd_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(function_id),
        .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_data),
        .tpu_funct(tpu_funct), .tpu_input0(tpu_input0), .tpu_input1(tpu_input1),
        .tpu_result(tpu_result), .tpu_done(tpu_done), .tpu_abort(tpu_abort),
        .seq_busy(seq_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // presents one command for a single cycle; returns one cycle after the handshake
    task automatic send(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        function_id = fid; in0 = a; in1 = b; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; function_id = '0; in0 = '0; in1 = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  rsp_data, 32'd0);
        chk({tag, "_funct"},     32'(tpu_funct), 32'd0);
        chk({tag, "_in0"},       tpu_input0, 32'd0);
        chk({tag, "_in1"},       tpu_input1, 32'd0);
        chk({tag, "_abort"},     32'(tpu_abort), 32'd0);
        chk({tag, "_busy"},      32'(seq_busy), 32'd0);
    endtask

    initial begin
        #2;
        chk_reset_outs("rst");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // opcode 2: one-cycle strobe with latched operands, response 0 at T+3
        chk("op2_ready_T", 32'(cmd_ready), 32'd1);
        send(10'd2, 32'h0102_0304, 32'h0506_0708);
        chk("op2_funct_T1", 32'(tpu_funct), 32'd2);
        chk("op2_in0_T1", tpu_input0, 32'h0102_0304);
        chk("op2_in1_T1", tpu_input1, 32'h0506_0708);
        chk("op2_ready_T1", 32'(cmd_ready), 32'd0);
        chk("op2_busy_T1", 32'(seq_busy), 32'd1);
        tick();
        chk("op2_funct_T2", 32'(tpu_funct), 32'd0);
        chk("op2_rspv_T2", 32'(rsp_valid), 32'd0);
        tick();
        chk("op2_rspv_T3", 32'(rsp_valid), 32'd1);
        chk("op2_data_T3", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("op2_idle_rspv", 32'(rsp_valid), 32'd0);
        chk("op2_idle_ready", 32'(cmd_ready), 32'd1);

        // opcode 7: capture tpu_result in CAPTURE, hold response 5 cycles
        send(10'd7, 32'h11, 32'h22);
        chk("op7_funct", 32'(tpu_funct), 32'd7);
        tick();
        tpu_result = 32'h0000_0ABC;
        tick();
        tpu_result = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("op7_hold_rspv", 32'(rsp_valid), 32'd1);
            chk("op7_hold_data", rsp_data, 32'h0000_0ABC);
            chk("op7_hold_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        tpu_result = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("op7_done_ready", 32'(cmd_ready), 32'd1);

        // upper function_id bits ignored: 0x3F9 decodes as opcode 1, response cleared to 0
        send(10'h3F9, 32'h5, 32'h6);
        chk("op1_funct", 32'(tpu_funct), 32'd1);
        tick(); tick();
        chk("op1_data", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        tick();

        // opcode 4 with tpu_done 10 cycles after ISSUE, rsp_ready held high in advance
        send(10'd4, 32'hA, 32'hB);
        chk("op4_funct", 32'(tpu_funct), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("op4_wait_rspv", 32'(rsp_valid), 32'd0);
        end
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        chk("op4_rspv", 32'(rsp_valid), 32'd1);
        chk("op4_data", rsp_data, 32'd10);
        tick();
        chk("op4_one_cycle_resp", 32'(cmd_ready), 32'd1);

        // stray tpu_done in IDLE is ignored
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        chk("idle_done_ready", 32'(cmd_ready), 32'd1);
        chk("idle_done_busy", 32'(seq_busy), 32'd0);

        // opcode 6 returns last compute count at T+1
        send(10'd6, 32'h0, 32'h0);
        chk("op6_funct", 32'(tpu_funct), 32'd0);
        chk("op6_rspv", 32'(rsp_valid), 32'd1);
        chk("op6_data", rsp_data, 32'd10);
        tick();

        // opcode 0: response 0 at T+1, no strobe
        send(10'd0, 32'h7, 32'h8);
        chk("op0_funct", 32'(tpu_funct), 32'd0);
        chk("op0_rspv", 32'(rsp_valid), 32'd1);
        chk("op0_data", rsp_data, 32'd0);
        tick();
        rsp_ready = 1'b0;

        // asynchronous reset in the middle of WAIT_DONE
        send(10'd4, 32'hCAFE_0001, 32'hCAFE_0002);
        tick(); tick();
        chk("mid_busy", 32'(seq_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        #1;
        rst_n = 1'b1;
        tick();
        send(10'd6, 32'h0, 32'h0);
        chk("post_rst_op6_rspv", 32'(rsp_valid), 32'd1);
        chk("post_rst_op6_data", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

`ifdef TPU_SEQ_TIMEOUT_EN
        // no tpu_done: limit 8 reached in cycle T+9, abort with response at T+10
        send(10'd4, 32'h1, 32'h2);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_wait_abort", 32'(tpu_abort), 32'd0);
        end
        tick();
        chk("to_rspv", 32'(rsp_valid), 32'd1);
        chk("to_abort", 32'(tpu_abort), 32'd1);
        chk("to_data", rsp_data, 32'hFFFF_FFFF);
        tick();
        chk("to_abort_one_cycle", 32'(tpu_abort), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        send(10'd6, 32'h0, 32'h0);
        chk("to_last_cnt_kept", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // tpu_done on the limit cycle wins
        send(10'd4, 32'h1, 32'h2);
        for (int i = 0; i < 8; i++) tick();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        chk("done_at_lim_rspv", 32'(rsp_valid), 32'd1);
        chk("done_at_lim_data", rsp_data, 32'd8);
        chk("done_at_lim_abort", 32'(tpu_abort), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
